logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-003 Port rst_n  input  1: reset, synchronous and active-low.
REQ-004 Port req0_valid  input  1: requester 0 has an operation pending.
REQ-005 Port req0_ready  output  1: requester 0 operation accepted this cycle.
REQ-006 Port req0_a, req0_b  input  WIDTH each: requester 0 operands.
REQ-007 Port req0_op  input  2: requester 0 opcode.
REQ-008 Ports req1_valid, req1_ready, req1_a, req1_b, req1_op: identical to REQ-004..007, for requester 1.
REQ-009 Port rsp_valid  output  1: result available.
REQ-010 Port rsp_ready  input  1: consumer accepts the result.
REQ-011 Port rsp_id  output  1: index of the requester that owns the result.
REQ-012 Port rsp_result  output  WIDTH: operation result.
REQ-013 Port busy  output  1: high in every state except IDLE.

Function
REQ-014 Opcodes SHALL be: 00 A AND B; 01 A OR B; 10 A XOR B; 11 NOR(A,B). All four SHALL be valid.
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE, at most one reqN_ready SHALL be high, combinationally, and only for the granted requester with reqN_valid=1. Outside IDLE, both ready outputs SHALL be 0.
REQ-017 A handshake (reqN_valid & reqN_ready) in IDLE SHALL register operands, opcode and id, then move to EXEC.
REQ-018 EXEC SHALL compute the operation from the registered operands, register the result into rsp_result, and move to RESP after exactly 1 cycle.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_result and rsp_id SHALL stay stable until rsp_ready=1. On that cycle the FSM SHALL return to IDLE.
REQ-020 Latency: handshake at cycle N SHALL give rsp_valid=1 at cycle N+2. Peak throughput SHALL be one operation per 3 cycles.
REQ-021 If rsp_ready is already high when RESP is entered, the result SHALL be consumed in that cycle. A new request SHALL be accepted no earlier than the following cycle.
REQ-022 If only one requester is valid in IDLE, it SHALL be granted regardless of arbitration history.
REQ-023 If both requesters are valid in IDLE, the winner SHALL follow the arbitration policy in REQ-029/REQ-030.
REQ-024 A requester SHALL hold valid and its operands stable until ready. If valid drops before grant, the request SHALL be ignored with no state change.
REQ-025 The result SHALL be exactly WIDTH bits, with no carry or status flags.

Reset
REQ-026 While rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE and all registered outputs SHALL clear: rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, both ready outputs=0. The arbitration pointer SHALL be set to prefer requester 0.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no rsp_valid pulse.
REQ-028 The first edge with rst_n=1 SHALL be an IDLE cycle, able to grant.

Configuration
REQ-029 With macro LOGIC_ARB_RR_EN defined, arbitration SHALL be round-robin. A 1-bit pointer SHALL be updated on each accepted handshake to prefer the non-granted requester. On a tie, the preferred requester wins.
REQ-030 With LOGIC_ARB_RR_EN undefined, arbitration SHALL be fixed priority: requester 0 always wins ties and no pointer register exists. All other behaviour SHALL be identical.

Verification
REQ-031 Reset, then req0 with a=0xF0F0F0F0, b=0xFF00FF00, op=00 -> req0_ready in cycle 0; rsp_valid at cycle 2 with rsp_result=0xF000F000, rsp_id=0.
REQ-032 Opcode sweep with a=0x0000FFFF, b=0x00FF00FF and rsp_ready held 1 -> op=01 gives 0x00FFFFFF; op=10 gives 0x00FFFF00; op=11 gives 0xFF000000.
REQ-033 Both requesters valid continuously for 4 operations, rsp_ready=1 -> with LOGIC_ARB_RR_EN, grant order is 0,1,0,1; without it, grant order is 0,0,0,0.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_result and rsp_id stay stable; both ready outputs stay 0 and busy=1 throughout. After rsp_ready=1, IDLE follows on the next cycle.
REQ-035 rst_n=0 for one cycle while in EXEC -> no rsp_valid pulse; all outputs are 0 on the next cycle. A request presented afterwards completes normally with correct latency.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two-requester bitwise logic unit behind an IDLE/EXEC/RESP handshake FSM.
// Define LOGIC_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             gnt0, gnt1, idle, hs;
`ifdef LOGIC_ARB_RR_EN
  logic ptr_q, ptr_d;
  // ptr_q=1 means requester 1 wins the next tie
  assign gnt0 = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1 = req1_valid & (~req0_valid | ptr_q);
  assign ptr_d = hs ? gnt0 : ptr_q;
  always_ff @(posedge clk)
    if (!rst_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
`else
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid & ~req0_valid;
`endif
  assign idle       = rst_n & (state_q == IDLE);
  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;
  assign hs         = req0_ready | req1_ready;
  assign busy       = state_q != IDLE;
  assign rsp_valid  = state_q == RESP;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  always_comb begin
    a_d      = hs ? (gnt0 ? req0_a : req1_a) : a_q;
    b_d      = hs ? (gnt0 ? req0_b : req1_b) : b_q;
    op_d     = hs ? (gnt0 ? req0_op : req1_op) : op_q;
    id_d     = hs ? ~gnt0 : id_q;
    result_d = state_q != EXEC ? result_q :
               op_q == 2'b00 ? a_q & b_q :
               op_q == 2'b01 ? a_q | b_q :
               op_q == 2'b10 ? a_q ^ b_q : ~(a_q | b_q);
    state_d  = state_q == IDLE ? (hs ? EXEC : IDLE) :
               state_q == EXEC ? RESP :
               state_q == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: transaction-level model check every cycle plus directed literal checks.
module tb_logic_unit_arbiter;
`ifdef LOGIC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, req0_valid, req1_valid, rsp_ready;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_result;
  logic [1:0] req0_op, req1_op;
  int errs = 0, checks = 0;
  bit started = 1'b0;
  bit m_job = 1'b0, m_id = 1'b0, m_ptr = 1'b0;
  int m_age = 0;
  logic [31:0] m_res = '0;
  int got [4];
  int exp_order [4];
  logic [31:0] sweep_exp [3];
  bit sweep_id [3];

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] opfn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00: return a & b;
      2'b01: return a | b;
      2'b10: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int winner();
    if (req0_valid && req1_valid) return RR ? 32'(m_ptr) : 0;
    return req0_valid ? 0 : 1;
  endfunction

  function automatic bit exp_ready(input int i);
    return rst_n && !m_job && (i == 1 ? req1_valid : req0_valid) && winner() == i;
  endfunction

  // Model: an accepted job is one cycle in compute, then presented until consumed.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_job = 1'b0; m_ptr = 1'b0; started = 1'b1;
    end else if (m_job) begin
      if (m_age >= 2 && rsp_ready) m_job = 1'b0;
      else m_age++;
    end else if (exp_ready(0) || exp_ready(1)) begin
      m_id  = exp_ready(1);
      m_res = m_id ? opfn(req1_op, req1_a, req1_b) : opfn(req0_op, req0_a, req0_b);
      m_job = 1'b1; m_age = 1; m_ptr = !m_id;
    end
  end

  always @(negedge clk)
    if (started) begin
      chk("m_ready0", 32'(req0_ready), 32'(exp_ready(0)));
      chk("m_ready1", 32'(req1_ready), 32'(exp_ready(1)));
      chk("m_busy", 32'(busy), 32'(m_job));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_job && m_age >= 2));
      if (m_job && m_age >= 2) begin
        chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("m_rsp_result", rsp_result, m_res);
      end
    end

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, output int k);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    k = -1;
    for (int i = 0; i < 20 && k < 0; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) k = i;
    end
    if (k < 0) chk("issue_timeout", 32'(k), 32'd0);
    @(posedge clk); #2;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] res, input bit id);
    int k = -1;
    for (int i = 1; i <= 10 && k < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) k = i;
    end
    chk({name, "_latency"}, 32'(k), 32'd2);
    chk({name, "_result"}, rsp_result, res);
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  initial begin
    int k, n;
    exp_order = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    sweep_exp = '{32'h00FF_FFFF, 32'h00FF_FF00, 32'hFF00_0000};
    sweep_id  = '{1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; rsp_ready = 1'b0; req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = '0;
    @(posedge clk); @(posedge clk); #2;
    @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; rsp_ready = 1'b1;
    issue(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, k);
    chk("first_ready_cycle", 32'(k), 32'd0);
    wait_rsp("first", 32'hF000_F000, 1'b0);
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      issue(sweep_id[i], 32'h0000_FFFF, 32'h00FF_00FF, 2'(i + 1), k);
      wait_rsp($sformatf("sweep_op%0d", i + 1), sweep_exp[i], sweep_id[i]);
      @(posedge clk); #2;
    end
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 32'h8765_4321; req1_b = 32'hF0F0_F0F0; req1_op = 2'b01;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready) begin got[n] = 0; n++; end
      else if (req1_ready) begin got[n] = 1; n++; end
    end
    @(posedge clk); #2;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("arb_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) chk($sformatf("arb_grant%0d", i), 32'(got[i]), 32'(exp_order[i]));
    repeat (4) @(posedge clk);
    #2;
    rsp_ready = 1'b0;
    issue(1'b1, 32'hAAAA_5555, 32'h0000_FFFF, 2'b11, k);
    wait_rsp("stall", 32'h5555_0000, 1'b1);
    @(posedge clk); #2;
    req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0000_0F0F; req0_op = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, 32'h5555_0000);
      chk("stall_id", 32'(rsp_id), 32'd1);
      chk("stall_ready0", 32'(req0_ready), 32'd0);
      chk("stall_ready1", 32'(req1_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    issue(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'b10, k);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    chk("post_rst_result", rsp_result, 32'd0);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #2;
    issue(1'b0, 32'h0000_000F, 32'h0000_00FF, 2'b01, k);
    wait_rsp("after_rst", 32'h0000_00FF, 1'b0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
endmodule
